// File: rtl/seq_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// seq_multiplier_pkg
// Shared definitions for the sequential shift-add multiplier.
//   mulState_e : controller states (IDLE waits for a request, CALC performs
//                one partial product per cycle, FIN applies the sign and
//                registers the result).
//   cntWidth() : width of the iteration counter for a given operand width,
//                sized so the counter can hold the value WIDTH.
// ---------------------------------------------------------------------------
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } mulState_e;

  // Counter width CNT_W = $clog2(WIDTH+1) for the multiplier instance.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_shift_add_step.sv
// ---------------------------------------------------------------------------
// shift_add_step
// One iteration of the shift-add multiply: conditionally adds the
// multiplicand into the upper half of the {acc, multiplier} pair, keeping
// the carry, then shifts the whole pair right by one bit.
// Ports:
//   i_acc      : current accumulator (upper half of the pair)
//   i_mcand    : multiplicand magnitude
//   i_mplier   : current multiplier (lower half of the pair); bit 0 decides
//                whether the multiplicand is added this step
//   o_acc      : accumulator after add and shift
//   o_mplier   : multiplier after shift, with the sum's LSB shifted in
// ---------------------------------------------------------------------------
module shift_add_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mplier
);

  logic [WIDTH:0] w_sum;

  // The add is WIDTH+1 bits wide so the carry out of the accumulator is
  // kept; it becomes the new accumulator MSB after the shift.
  always_comb begin
    w_sum = {1'b0, i_acc};
    if (i_mplier[0]) begin
      w_sum = {1'b0, i_acc} + {1'b0, i_mcand};
    end
  end

  // Right shift of the concatenated {sum, multiplier} pair: the sum's LSB
  // moves into the top of the multiplier half, which ends up holding the
  // low half of the product once all iterations are done.
  assign o_acc    = w_sum[WIDTH:1];
  assign o_mplier = {w_sum[0], i_mplier[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Sequential shift-add multiplier producing a full 2*WIDTH-bit product in
// WIDTH+1 cycles, with optional two's-complement operands and an overflow
// flag for a WIDTH-bit result path.
// Ports:
//   i_clk         : rising-edge clock
//   i_rst_n       : synchronous active-low reset
//   i_start       : request, only looked at while idle
//   i_signed_mode : 1 = signed operands/product, 0 = unsigned (with start)
//   i_a, i_b      : multiplicand and multiplier (captured with start)
//   o_busy        : high while a product is being computed
//   o_done        : single-cycle pulse when o_p/o_overflow are new
//   o_p           : product, held until the next done
//   o_overflow    : product does not fit in WIDTH bits (signed or unsigned)
// ---------------------------------------------------------------------------
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_signed_mode,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_p,
  output logic                 o_overflow
);

  localparam int CNT_W = cntWidth(WIDTH);
  localparam int PW    = 2 * WIDTH;

  mulState_e r_state;
  mulState_e w_nextState;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;
  logic             r_overflow;
  logic [PW-1:0]    r_p;

  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;
  logic [WIDTH-1:0] w_stepAcc;
  logic [WIDTH-1:0] w_stepMplier;
  logic [PW-1:0]    w_product;
  logic [PW-1:0]    w_pFinal;
  logic             w_overflow;
  logic             w_lastIter;

  // Operand magnitudes. Negating the most negative value wraps back to the
  // same bit pattern, which read as unsigned is exactly 2^(WIDTH-1), so the
  // WIDTH-bit magnitude register is always wide enough.
  assign w_magA = (i_signed_mode && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_magB = (i_signed_mode && i_b[WIDTH-1]) ? -i_b : i_b;

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_stepAcc),
    .o_mplier (w_stepMplier)
  );

  // After the last iteration the {acc, multiplier} pair holds the unsigned
  // product of the magnitudes; the sign is reapplied here. A zero product
  // stays zero when negated, so no special case is needed for zero operands.
  assign w_product = {r_acc, r_mplier};
  assign w_pFinal  = r_neg ? -w_product : w_product;

  // Unsigned: any set bit in the upper half means the result needs more
  // than WIDTH bits. Signed: the upper half plus the result sign bit must be
  // a pure sign extension (all ones or all zeros) to fit in WIDTH bits.
  always_comb begin
    w_overflow = 1'b0;
    if (r_mode) begin
      w_overflow = !((&w_pFinal[PW-1:WIDTH-1]) || !(|w_pFinal[PW-1:WIDTH-1]));
    end else begin
      w_overflow = |w_pFinal[PW-1:WIDTH];
    end
  end

  assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

  // State register for the controller.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a request is only honoured while idle, CALC runs for
  // exactly WIDTH iterations, and FIN always returns to IDLE so a new start
  // can be accepted in the same cycle that done is high.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (i_start) w_nextState = CALC;
      CALC: if (w_lastIter) w_nextState = FIN;
      FIN:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath and registered outputs. Operands are captured only on an
  // accepted start, so input changes while busy are ignored. Busy is
  // registered from the next state so it rises with the accepting edge and
  // falls with the edge that raises done.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_mode     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_p        <= '0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_nextState != IDLE);
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mcand  <= w_magA;
            r_mplier <= w_magB;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= i_signed_mode & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_mode   <= i_signed_mode;
          end
        end
        CALC: begin
          r_acc    <= w_stepAcc;
          r_mplier <= w_stepMplier;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        FIN: begin
          r_p        <= w_pFinal;
          r_overflow <= w_overflow;
          r_done     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_p        = r_p;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Self-checking bench for seq_multiplier. Three instances (WIDTH 4, 8, 16)
// share one operand bus and reset; each has its own start line. Expected
// products come from a constant vector table and from an arithmetic
// reference model using plain integer multiplication.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] tbA;
  logic [31:0] tbB;
  logic        tbSigned;
  logic        start4;
  logic        start8;
  logic        start16;

  logic        busy4, done4, ov4;
  logic [7:0]  p4;
  logic        busy8, done8, ov8;
  logic [15:0] p8;
  logic        busy16, done16, ov16;
  logic [31:0] p16;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    bit          sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    bit          ov;
  } vec_t;

  vec_t vecs [11];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start4), .i_signed_mode(tbSigned),
    .i_a(tbA[3:0]), .i_b(tbB[3:0]),
    .o_busy(busy4), .o_done(done4), .o_p(p4), .o_overflow(ov4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start8), .i_signed_mode(tbSigned),
    .i_a(tbA[7:0]), .i_b(tbB[7:0]),
    .o_busy(busy8), .o_done(done8), .o_p(p8), .o_overflow(ov8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start16), .i_signed_mode(tbSigned),
    .i_a(tbA[15:0]), .i_b(tbB[15:0]),
    .o_busy(busy16), .o_done(done16), .o_p(p16), .o_overflow(ov16)
  );

  // Compare one observed value with its expected value and keep the tally.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Reference product: interpret the low w bits of each operand as signed or
  // unsigned integers, multiply, and judge overflow by the numeric range of
  // a w-bit result.
  function automatic void refModel(input int w, input bit sm,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [63:0] p, output bit ov);
    longint mask;
    longint av;
    longint bv;
    longint prod;
    mask = (longint'(1) << w) - 1;
    av   = longint'(a) & mask;
    bv   = longint'(b) & mask;
    if (sm) begin
      if (av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
      if (bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
    end
    prod = av * bv;
    if (sm) begin
      ov = (prod < -(longint'(1) << (w - 1))) || (prod > ((longint'(1) << (w - 1)) - 1));
    end else begin
      ov = (prod > mask);
    end
    p = 64'(prod) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic setStart(input int w, input logic v);
    case (w)
      4:       start4  = v;
      16:      start16 = v;
      default: start8  = v;
    endcase
  endtask

  function automatic logic getDone(input int w);
    case (w)
      4:       return done4;
      16:      return done16;
      default: return done8;
    endcase
  endfunction

  function automatic logic getBusy(input int w);
    case (w)
      4:       return busy4;
      16:      return busy16;
      default: return busy8;
    endcase
  endfunction

  function automatic logic getOv(input int w);
    case (w)
      4:       return ov4;
      16:      return ov16;
      default: return ov8;
    endcase
  endfunction

  function automatic logic [63:0] getP(input int w);
    case (w)
      4:       return 64'(p4);
      16:      return 64'(p16);
      default: return 64'(p8);
    endcase
  endfunction

  // Issue one request to the selected instance and wait (bounded) for done.
  // lat counts rising edges from the accepting edge to the edge raising done.
  task automatic applyStimulus(input int w, input bit sm,
                               input logic [31:0] a, input logic [31:0] b,
                               output logic [63:0] p, output bit ov,
                               output int lat, output bit busyEarly);
    @(negedge clk);
    tbA = a;
    tbB = b;
    tbSigned = sm;
    setStart(w, 1'b1);
    @(negedge clk);
    setStart(w, 1'b0);
    busyEarly = getBusy(w);
    lat = 0;
    while (!getDone(w) && lat < w + 8) begin
      @(negedge clk);
      lat++;
    end
    p  = getP(w);
    ov = getOv(w);
  endtask

  // Random operand pairs in both modes against the reference model.
  task automatic randomRun(input int w, input int n);
    logic [63:0] p, ep;
    bit          ov, eov, busyEarly, sm;
    int          lat;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      applyStimulus(w, sm, a, b, p, ov, lat, busyEarly);
      refModel(w, sm, a, b, ep, eov);
      checkOutput($sformatf("w%0d rand p a=%0h b=%0h s=%0d", w, a, b, sm), p, ep);
      checkOutput($sformatf("w%0d rand ov a=%0h b=%0h s=%0d", w, a, b, sm), 64'(ov), 64'(eov));
      checkOutput($sformatf("w%0d rand latency", w), 64'(lat), 64'(w + 1));
    end
  endtask

  initial begin
    logic [63:0] p, ep;
    bit          ov, eov, busyEarly;
    int          lat;
    int          doneCount;

    vecs[0]  = '{"u 255x255",   1'b0, 8'd255, 8'd255, 16'hFE01, 1'b1};
    vecs[1]  = '{"u 13x11",     1'b0, 8'd13,  8'd11,  16'h008F, 1'b0};
    vecs[2]  = '{"s -128x-128", 1'b1, 8'h80,  8'h80,  16'h4000, 1'b1};
    vecs[3]  = '{"s -3x5",      1'b1, 8'hFD,  8'd5,   16'hFFF1, 1'b0};
    vecs[4]  = '{"s -1x-1",     1'b1, 8'hFF,  8'hFF,  16'h0001, 1'b0};
    vecs[5]  = '{"u 0x200",     1'b0, 8'd0,   8'd200, 16'h0000, 1'b0};
    vecs[6]  = '{"s 0x-5",      1'b1, 8'd0,   8'hFB,  16'h0000, 1'b0};
    vecs[7]  = '{"s 127x-128",  1'b1, 8'h7F,  8'h80,  16'hC080, 1'b1};
    vecs[8]  = '{"u 200x2",     1'b0, 8'd200, 8'd2,   16'h0190, 1'b1};
    vecs[9]  = '{"s -128x1",    1'b1, 8'h80,  8'd1,   16'hFF80, 1'b0};
    vecs[10] = '{"u 7x6",       1'b0, 8'd7,   8'd6,   16'h002A, 1'b0};

    rstN = 1'b0;
    tbA = '0;
    tbB = '0;
    tbSigned = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
    start16 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of all instances.
    checkOutput("reset busy8", 64'(busy8), 64'd0);
    checkOutput("reset done8", 64'(done8), 64'd0);
    checkOutput("reset p8", 64'(p8), 64'd0);
    checkOutput("reset ov8", 64'(ov8), 64'd0);
    checkOutput("reset p4", 64'(p4), 64'd0);
    checkOutput("reset p16", 64'(p16), 64'd0);
    rstN = 1'b1;

    // Vector table on the 8-bit instance.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(8, vecs[i].sm, 32'(vecs[i].a), 32'(vecs[i].b), p, ov, lat, busyEarly);
      checkOutput({vecs[i].name, " p"}, p, 64'(vecs[i].p));
      checkOutput({vecs[i].name, " ov"}, 64'(ov), 64'(vecs[i].ov));
      checkOutput({vecs[i].name, " latency"}, 64'(lat), 64'd9);
      checkOutput({vecs[i].name, " busy after start"}, 64'(busyEarly), 64'd1);
      @(negedge clk);
      checkOutput({vecs[i].name, " done pulse width"}, 64'(done8), 64'd0);
      checkOutput({vecs[i].name, " p held"}, 64'(p8), 64'(vecs[i].p));
    end

    // Start held high with changing operands while busy: only the first
    // request counts; the next one is accepted in the done cycle.
    @(negedge clk);
    tbA = 32'd3;
    tbB = 32'd4;
    tbSigned = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done8 && lat < 20) begin
      tbA = $urandom;
      tbB = $urandom;
      tbSigned = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    checkOutput("busy-start first latency", 64'(lat), 64'd9);
    checkOutput("busy-start first p", 64'(p8), 64'd12);
    checkOutput("busy-start first ov", 64'(ov8), 64'd0);
    tbA = 32'd5;
    tbB = 32'd6;
    tbSigned = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("back-to-back accepted", 64'(busy8), 64'd1);
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("back-to-back latency", 64'(lat), 64'd9);
    checkOutput("back-to-back p", 64'(p8), 64'd30);

    // Reset in the middle of a calculation discards it without a done.
    @(negedge clk);
    tbA = 32'd100;
    tbB = 32'd100;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("mid reset busy", 64'(busy8), 64'd0);
    checkOutput("mid reset done", 64'(done8), 64'd0);
    checkOutput("mid reset p", 64'(p8), 64'd0);
    checkOutput("mid reset ov", 64'(ov8), 64'd0);
    rstN = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) doneCount++;
    end
    checkOutput("no done after reset", 64'(doneCount), 64'd0);
    applyStimulus(8, 1'b0, 32'd7, 32'd6, p, ov, lat, busyEarly);
    checkOutput("after reset 7x6 p", p, 64'd42);
    checkOutput("after reset 7x6 latency", 64'(lat), 64'd9);

    // Boundary operands through the reference model on the wide instance.
    applyStimulus(16, 1'b1, 32'h8000, 32'h8000, p, ov, lat, busyEarly);
    refModel(16, 1'b1, 32'h8000, 32'h8000, ep, eov);
    checkOutput("w16 s min x min p", p, ep);
    checkOutput("w16 s min x min ov", 64'(ov), 64'(eov));
    applyStimulus(4, 1'b0, 32'hF, 32'hF, p, ov, lat, busyEarly);
    refModel(4, 1'b0, 32'hF, 32'hF, ep, eov);
    checkOutput("w4 u max x max p", p, ep);
    checkOutput("w4 u max x max ov", 64'(ov), 64'(eov));

    randomRun(4, 1000);
    randomRun(8, 300);
    randomRun(16, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier, the multi-cycle successor to the ALU's combinational 8×8 array multiplier. Accepts two WIDTH-bit operands on a start pulse and computes the full 2·WIDTH-bit product in WIDTH+1 cycles, one partial product per cycle, so area stays flat as WIDTH grows. Adds signed (two's-complement) mode, a start/busy/done handshake, and a working overflow flag for the ALU's WIDTH-bit result path.

## Interface
- WIDTH, 8: operand width; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands/product, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while a product is in progress (CALC, FIN).
- done  output  1  one-cycle pulse; p/overflow are new in this cycle.
- p  output  2·WIDTH  product; held until the next done.
- overflow  output  1  product does not fit a WIDTH-bit result; held with p.

## Operation
- States: IDLE, CALC, FIN. Reset -> IDLE, p=0, overflow=0, done=0, busy=0, counter=0, internal registers 0.
- IDLE: start=1 -> latch |a|, |b| (magnitudes if signed_mode, raw otherwise), neg = signed_mode & (a[MSB]^b[MSB]), mode; clear accumulator and counter; -> CALC. start=0 -> stay.
- CALC: each cycle, if multiplier LSB=1, add multiplicand to the accumulator upper half (WIDTH+1-bit add, carry kept); shift {acc, multiplier} right by one; counter+1. After WIDTH iterations -> FIN.
- FIN: p = neg ? -acc : acc (2·WIDTH-bit two's complement); overflow computed from the final p; done=1 next cycle; -> IDLE.
- Magnitude rule: |−2^(WIDTH−1)| = 2^(WIDTH−1) fits the WIDTH-bit unsigned magnitude register; no extra bit is needed.
- Overflow, unsigned: p[2W−1:W] != 0. Signed: p[2W−1:W−1] not all-equal, i.e. not representable as WIDTH-bit signed.
- Zero operand: runs full latency, no early exit; p=0, overflow=0, neg suppressed (−0 = 0 by arithmetic).
- start while busy: ignored, no queueing; a/b/signed_mode changes while busy have no effect.
- rst_n low in any state: next edge -> IDLE with all outputs at reset values; an in-flight product is discarded and no done is issued.

## Timing
- Start sampled at edge t0 -> busy=1 from t0. CALC at edges t0+1..t0+WIDTH. FIN edge t0+WIDTH+1 registers p/overflow, done=1, busy=0.
- Latency start-edge to done: WIDTH+1 cycles (9 for WIDTH=8). Throughput: one product per WIDTH+1 cycles.
- done is a registered single-cycle pulse; in the done cycle the FSM is in IDLE and a new start is accepted (back-to-back, no bubble).
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package/header: state encodings (IDLE, CALC, FIN), counter width CNT_W = $clog2(WIDTH+1).
- One sub-module: shift_add_step — combinational WIDTH+1-bit conditional add plus one-bit right shift of the {acc, multiplier} pair; parametrised by WIDTH. FSM, counter, sign handling and overflow stay in the top.

## Test plan
- WIDTH=8 unsigned 255×255 -> p=0xFE01, overflow=1, done exactly 9 cycles after start edge; 13×11 -> p=143 (0x008F), overflow=0.
- WIDTH=8 signed −128×−128 -> p=0x4000, overflow=1; −3×5 -> p=0xFFF1, overflow=0; −1×−1 -> p=0x0001, overflow=0.
- start pulsed every cycle with changing a/b while busy -> only first request computed; next accepted in the done cycle, second done 9 cycles later.
- rst_n low at CALC cycle 4 -> next edge busy=0, p=0, overflow=0, no done pulse; subsequent 7×6 -> p=42.
- Zero: 0×200 unsigned and 0×−5 signed -> p=0, overflow=0, full 9-cycle latency.
- WIDTH=4 and WIDTH=16 builds: randomised 1000 operand pairs both modes vs behavioural model -> p, overflow, latency WIDTH+1 all match.
